bcd_frame_conv: RTL
===================

Name: bcd_frame_conv

Overview:
- Per-frame binary-to-BCD converter. It sits directly upstream of the character/font RGB selector in the vga top level.
- On a start pulse (the vsync rising edge), it snapshots NUM packed binary values and converts each to DIGITS BCD digits using a sequential shift-add-3 (double-dabble) engine.
- It publishes all digits atomically, so the renderer always sees a coherent frame of decimal numbers.

Parameters:
- NUM, 36, number of packed values converted per start.
- BIN_W, 10, width of each binary value.
- DIGITS, 3, BCD digits produced per value; output saturates at 10^DIGITS-1.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- RST  input  1  synchronous, active-high reset.
- start  input  1  conversion request, sampled each cycle.
- bin  input  NUM*BIN_W  packed values; value i = bin[i*BIN_W +: BIN_W].
- dec  output  NUM*DIGITS*4  packed BCD, registered; slot i = dec[i*DIGITS*4 +: DIGITS*4]; most significant digit in the highest nibble.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse in the cycle the new dec becomes valid.

Behaviour:
- Reset: RST is sampled on clk and has priority over everything. It forces state=IDLE, idx=0, dec=0, busy=0, done=0, and clears the work registers.
- Reset mid-conversion aborts the conversion. dec reads 0 and is never partially updated.
- States are IDLE, LOAD, SHIFT, STORE, DONE.
  - IDLE: if start=1 at edge T, snapshot bin into bin_q, set idx=0, go to LOAD. Later changes to bin have no effect until the next accepted start.
  - LOAD (1 cycle): shift register = {DIGITS*4 zeros, bin_q slot idx}; bit counter = BIN_W.
  - SHIFT (BIN_W cycles): each cycle, every BCD nibble ≥5 gets +3, then the whole register shifts left by 1. Leave after the BIN_W-th shift.
  - STORE (1 cycle): write the DIGITS digits into work slot idx. If bin_q slot idx ≥ 10^DIGITS, write all nines instead. If idx==NUM-1, go to DONE; else idx+1, go to LOAD.
  - DONE (1 cycle): dec <= work buffer (all slots at once), done=1, go to IDLE.
- Latency:
  - Each value takes BIN_W+2 cycles.
  - busy=1 from cycle T+1 through T+1+NUM*(BIN_W+2) inclusive.
  - done=1 and the new dec are visible in cycle T+1+NUM*(BIN_W+2). With defaults this is T+433.
- dec holds the previous frame's values for the whole conversion and changes only on the DONE edge.
- A start while busy (including in the DONE cycle) is ignored and not queued. A start in the cycle after done is accepted.
- Width rules:
  - The shift register is DIGITS*4+BIN_W bits.
  - The idx counter is clog2(NUM) bits, and NUM ≥ 1.
  - No carry out of the top digit can occur except in the saturated case.

Test Plan:
- Reset: hold RST=1 for 3 cycles with start=1 → dec=0, busy=0, done=0. Release RST with start=0 → still IDLE, no done.
- Conversion values: set slots 0..9 = 0, 1, 9, 10, 99, 100, 255, 999, 1000, 1023 and the rest = 0; pulse start → after done:
  - slots 0..7 = 000, 001, 009, 010, 099, 100, 255, 999;
  - slots 8 and 9 = 999 (saturated);
  - all other slots = 000.
- Timing: pulse start at edge T → busy rises at T+1, done is a single pulse at T+433, busy=0 at T+434. dec is unchanged in every cycle before T+433. Toggle bin randomly during busy → result still matches the snapshot.
- Start while busy: re-pulse start at T+100 and at the DONE cycle → exactly one done, at T+433. A start at T+434 → second done at T+434+433.
- Reset mid-conversion: assert RST at T+200 for 1 cycle → dec=0, busy=0, no done. A following start gives correct results with normal latency.
- Random: 50 frames of random 10-bit values → each slot equals min(v,999) in BCD, checked against a reference model.

Source files
------------

// File: rtl/bcd_frame_conv.sv
// Per-frame binary-to-BCD converter: snapshots NUM values on start, converts them one at a
// time with a double-dabble engine and publishes every digit at once.
//
// state | meaning
// IDLE  | waiting for start; dec holds the last frame
// LOAD  | load slot idx into the shift register, arm the bit counter
// SHIFT | BIN_W add-3/shift-left iterations
// STORE | write slot idx digits (saturated to all nines) into the work buffer
// DONE  | dec and done reflect the finished frame for one cycle
module bcd_frame_conv #(
    parameter int NUM    = 36,
    parameter int BIN_W  = 10,
    parameter int DIGITS = 3
) (
    input  logic                       clk,
    input  logic                       RST,
    input  logic                       start,
    input  logic [NUM*BIN_W-1:0]       bin,
    output logic [NUM*DIGITS*4-1:0]    dec,
    output logic                       busy,
    output logic                       done
);

    localparam int DEC_W = DIGITS * 4;
    localparam int SR_W  = DEC_W + BIN_W;
    localparam int IDX_W = (NUM > 1) ? $clog2(NUM) : 1;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [31:0]      LIMIT = 32'(10 ** DIGITS);
    localparam logic [DEC_W-1:0] NINES = {DIGITS{4'h9}};

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_STORE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]               state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [SR_W-1:0]          sr_q, sr_d;
    logic [NUM*BIN_W-1:0]     bin_q, bin_d;
    logic [NUM*DEC_W-1:0]     work_q, work_d;
    logic [NUM*DEC_W-1:0]     dec_q, dec_d;
    logic                     done_q, done_d;

    logic [BIN_W-1:0]         cur_bin;
    logic [SR_W-1:0]          sr_adj;
    logic [DEC_W-1:0]         digits;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        bin_d   = bin_q;
        work_d  = work_q;
        dec_d   = dec_q;
        done_d  = 1'b0;

        cur_bin = bin_q[idx_q*BIN_W +: BIN_W];

        sr_adj = sr_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (sr_q[BIN_W+4*k +: 4] >= 4'd5) begin
                sr_adj[BIN_W+4*k +: 4] = sr_q[BIN_W+4*k +: 4] + 4'd3;
            end
        end

        // Only a value beyond 10^DIGITS-1 can overflow the top digit, so it is replaced.
        if (32'(cur_bin) >= LIMIT) begin
            digits = NINES;
        end else begin
            digits = sr_q[SR_W-1 -: DEC_W];
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    bin_d   = bin;
                    idx_d   = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                sr_d    = {{DEC_W{1'b0}}, cur_bin};
                cnt_d   = CNT_W'(BIN_W);
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                sr_d  = sr_adj << 1;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_STORE;
                end
            end
            S_STORE: begin
                work_d[idx_q*DEC_W +: DEC_W] = digits;
                if (idx_q == IDX_W'(NUM - 1)) begin
                    // Publish on this edge so dec and done appear together in DONE.
                    dec_d   = work_d;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            sr_q    <= '0;
            bin_q   <= '0;
            work_q  <= '0;
            dec_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            bin_q   <= bin_d;
            work_q  <= work_d;
            dec_q   <= dec_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign dec  = dec_q;

endmodule
